fp_add_seq: RTL
===============

FP_ADD_SEQ -- requirements
Module: fp_add_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock, all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low; 0 = reset asserted.
REQ-003 SHALL have port start, input, 1 bit: request an operation, sampled only in IDLE.
REQ-004 SHALL have port op, input, 1 bit: 0 = A+B, 1 = A-B; sampled with start.
REQ-005 SHALL have ports a and b, input, 32 bits each: IEEE-754 single operands, captured on the accepting edge.
REQ-006 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-007 SHALL have port done, output, 1 bit: one-cycle pulse, high only in state DONE.
REQ-008 SHALL have port result, output, 32 bits: single-precision result, held stable from DONE until the next accepting edge.
REQ-009 SHALL have port flags, output, 3 bits: {invalid, overflow, underflow}, updated together with result.

Function
REQ-010 SHALL implement FSM IDLE -> UNPK -> ALGN -> ADDS -> NORM -> DONE -> IDLE, one state per clock, no stalls.
REQ-011 SHALL accept start only when state = IDLE; start while busy SHALL be ignored, with no queuing.
REQ-012 SHALL reach DONE exactly 4 rising edges after the accepting edge; result and flags SHALL be registered on the NORM->DONE edge; fixed latency for all operand values.
REQ-013 UNPK: split sign, 8-bit exponent, 24-bit mantissa with hidden bit; op=1 inverts sign of b; exponent 0 inputs (zero/denormal) flushed to +/-0.
REQ-014 ALGN: swap so the larger-magnitude operand is first; right-shift the smaller mantissa by the exponent difference in one cycle; difference >= 25 gives 0; shifted-out bits discarded.
REQ-015 ADDS: 25-bit add when signs are equal, else subtract smaller from larger; result sign = sign of larger magnitude.
REQ-016 NORM: carry-out gives right shift 1 and exponent +1; otherwise left shift by the leading-zero count of the 24-bit sum, with the exponent reduced by the same count; rounding is truncation (round toward zero).
REQ-017 An exact zero sum SHALL produce +0 (0x00000000), flags 000.
REQ-018 A normalized exponent >= 255 SHALL produce signed infinity with overflow=1.
REQ-019 A normalized exponent <= 0 SHALL produce signed zero with underflow=1.
REQ-020 Any NaN input, or inf + (-inf) after op, SHALL produce 0x7FC00000 with invalid=1.
REQ-021 Otherwise an infinite input SHALL produce that infinity with flags 000.
REQ-022 Special-case detection SHALL occur in UNPK; special cases SHALL still follow full latency.

Reset
REQ-023 reset=0 SHALL asynchronously force state IDLE, busy=0, done=0, result=0x00000000, flags=000, and all operand and pipeline registers to 0.
REQ-024 Reset asserted mid-operation SHALL abandon the operation with no done pulse; the first start after reset release SHALL be accepted normally.

Structure
REQ-025 Shared package fp_pkg SHALL hold the state encoding, FP_W=32, EXP_W=8, MAN_W=23, BIAS=127, QNAN=32'h7FC00000, and the infinity constants.
REQ-026 Leading-zero count SHALL be a separate combinational sub-module fp_lzc24 (24-bit in, 5-bit count).

Verification
REQ-027 a=0x3F800000, b=0x3F000000, op=0 -> result 0x3FC00000, flags 000, done exactly 4 edges after accept.
REQ-028 a=0x3FC00000, b=0x3E800000, op=0 -> 0x3FE00000; then 0x3FE00000 + 0x3E000000 -> 0x3FF00000.
REQ-029 a=0x3F800000, b=0x3F800000, op=1 -> 0x00000000, flags 000; a=0x7F7FFFFF, b=0x7F7FFFFF, op=0 -> 0x7F800000, overflow=1.
REQ-030 a=0x7F800000, b=0xFF800000, op=0 -> 0x7FC00000, invalid=1; a=0x7FC00001 with any b -> 0x7FC00000, invalid=1.
REQ-031 start pulsed again in ALGN with different operands -> ignored; first result delivered unchanged, single done pulse.
REQ-032 reset=0 driven in ADDS -> busy=0 and result=0 immediately, no done; new start after release -> correct result with 4-edge latency.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the sequential single-precision adder: FSM encoding,
// IEEE-754 field widths, special constants and the unpacked-operand payload.
package fp_pkg;

  localparam int unsigned FP_W  = 32;
  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;
  localparam int unsigned BIAS  = 127;
  localparam int unsigned SIG_W = MAN_W + 1;

  localparam logic [FP_W-1:0]  QNAN    = 32'h7FC0_0000;
  localparam logic [FP_W-1:0]  POS_INF = 32'h7F80_0000;
  localparam logic [FP_W-1:0]  NEG_INF = 32'hFF80_0000;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  // flags bit order is {invalid, overflow, underflow}
  localparam logic [2:0] FLG_NONE = 3'b000;
  localparam logic [2:0] FLG_INV  = 3'b100;
  localparam logic [2:0] FLG_OVF  = 3'b010;
  localparam logic [2:0] FLG_UNF  = 3'b001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UNPK,
    ST_ALGN,
    ST_ADDS,
    ST_NORM,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
  } unp_t;

  // Split a word into sign/exponent/significand; exponent-0 inputs flush to zero.
  function automatic unp_t unpack(input logic [FP_W-1:0] x, input logic neg);
    unp_t u;
    u.sign = x[FP_W-1] ^ neg;
    u.exp  = x[FP_W-2 -: EXP_W];
    u.sig  = (u.exp == '0) ? '0 : {1'b1, x[MAN_W-1:0]};
    return u;
  endfunction

  function automatic logic [FP_W-1:0] inf_of(input logic sign);
    return sign ? NEG_INF : POS_INF;
  endfunction

endpackage

// File: rtl/fp_lzc24.sv
// Leading-zero count of a 24-bit value; an all-zero input reports 24.
module fp_lzc24 (
  input  logic [23:0] value,
  output logic [4:0]  count
);

  // Ascending scan so the most significant set bit is the last to write.
  always_comb begin
    count = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (value[i]) count = 5'(23 - i);
    end
  end

endmodule

// File: rtl/fp_add_seq.sv
// Multi-cycle IEEE-754 single-precision adder/subtractor with truncation
// rounding and a fixed four-edge accept-to-done latency.
module fp_add_seq
  import fp_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            op,
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [FP_W-1:0] result,
  output logic [2:0]      flags
);

  state_t state, state_nx;
  logic   busy_nx, done_nx;

  logic [FP_W-1:0]  a_r, b_r;
  logic             op_r;
  unp_t             x_r, y_r;
  logic             spec_r;
  logic [FP_W-1:0]  spec_res_r;
  logic [2:0]       spec_flg_r;
  unp_t             big_r;
  logic [SIG_W-1:0] sml_r;
  logic             sub_r;
  logic [SIG_W:0]   sum_r;
  logic [EXP_W-1:0] exp_r;
  logic             sign_r;

  // State register and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= busy_nx;
      done  <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start) state_nx = ST_UNPK;
      ST_UNPK: state_nx = ST_ALGN;
      ST_ALGN: state_nx = ST_ADDS;
      ST_ADDS: state_nx = ST_NORM;
      ST_NORM: state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    busy_nx = (state_nx != ST_IDLE);
    done_nx = (state_nx == ST_DONE);
  end

  // UNPK: field split plus NaN/infinity classification.
  unp_t            ua, ub;
  logic            a_max, b_max, a_nan, b_nan, a_inf, b_inf;
  logic            unpk_spec;
  logic [FP_W-1:0] unpk_res;
  logic [2:0]      unpk_flg;

  always_comb begin
    ua        = unpack(a_r, 1'b0);
    ub        = unpack(b_r, op_r);
    a_max     = (a_r[FP_W-2 -: EXP_W] == EXP_MAX);
    b_max     = (b_r[FP_W-2 -: EXP_W] == EXP_MAX);
    a_nan     = a_max &&  (|a_r[MAN_W-1:0]);
    b_nan     = b_max &&  (|b_r[MAN_W-1:0]);
    a_inf     = a_max && !(|a_r[MAN_W-1:0]);
    b_inf     = b_max && !(|b_r[MAN_W-1:0]);
    unpk_spec = a_max || b_max;
    unpk_res  = '0;
    unpk_flg  = FLG_NONE;
    if (a_nan || b_nan || (a_inf && b_inf && (ua.sign != ub.sign))) begin
      unpk_res = QNAN;
      unpk_flg = FLG_INV;
    end else if (a_inf) begin
      unpk_res = inf_of(ua.sign);
    end else if (b_inf) begin
      unpk_res = inf_of(ub.sign);
    end
  end

  // ALGN: larger magnitude first, smaller significand shifted right.
  logic             swap;
  unp_t             big, sml;
  logic [EXP_W-1:0] diff;
  logic [SIG_W-1:0] sml_sh;

  always_comb begin
    swap   = ({y_r.exp, y_r.sig} > {x_r.exp, x_r.sig});
    big    = swap ? y_r : x_r;
    sml    = swap ? x_r : y_r;
    diff   = big.exp - sml.exp;
    sml_sh = (diff >= 8'd25) ? '0 : (sml.sig >> diff);
  end

  // ADDS: magnitude add or subtract; larger operand never goes negative.
  logic [SIG_W:0] sum_nx;

  always_comb begin
    if (sub_r) sum_nx = {1'b0, big_r.sig} - {1'b0, sml_r};
    else       sum_nx = {1'b0, big_r.sig} + {1'b0, sml_r};
  end

  // NORM: renormalize, truncate, then resolve zero/overflow/underflow.
  logic [4:0]       lz;
  logic [9:0]       norm_exp;
  logic [MAN_W-1:0] norm_frac;
  logic [FP_W-1:0]  norm_res;
  logic [2:0]       norm_flg;

  fp_lzc24 u_lzc (
    .value (sum_r[SIG_W-1:0]),
    .count (lz)
  );

  always_comb begin
    if (sum_r[SIG_W]) begin
      norm_exp  = {2'b00, exp_r} + 10'd1;
      norm_frac = sum_r[SIG_W-1:1];
    end else begin
      norm_exp  = {2'b00, exp_r} - {5'd0, lz};
      norm_frac = 23'(sum_r[SIG_W-1:0] << lz);
    end
    norm_res = '0;
    norm_flg = FLG_NONE;
    if (spec_r) begin
      norm_res = spec_res_r;
      norm_flg = spec_flg_r;
    end else if (sum_r == '0) begin
      norm_res = '0;
    end else if (norm_exp[9] || (norm_exp == 10'd0)) begin
      norm_res = {sign_r, 31'd0};
      norm_flg = FLG_UNF;
    end else if (norm_exp >= 10'd255) begin
      norm_res = inf_of(sign_r);
      norm_flg = FLG_OVF;
    end else begin
      norm_res = {sign_r, norm_exp[EXP_W-1:0], norm_frac};
    end
  end

  // Pipeline registers, each loaded only in the state that produces it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_r        <= '0;
      b_r        <= '0;
      op_r       <= 1'b0;
      x_r        <= '0;
      y_r        <= '0;
      spec_r     <= 1'b0;
      spec_res_r <= '0;
      spec_flg_r <= FLG_NONE;
      big_r      <= '0;
      sml_r      <= '0;
      sub_r      <= 1'b0;
      sum_r      <= '0;
      exp_r      <= '0;
      sign_r     <= 1'b0;
      result     <= '0;
      flags      <= FLG_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_r  <= a;
            b_r  <= b;
            op_r <= op;
          end
        end
        ST_UNPK: begin
          x_r        <= ua;
          y_r        <= ub;
          spec_r     <= unpk_spec;
          spec_res_r <= unpk_res;
          spec_flg_r <= unpk_flg;
        end
        ST_ALGN: begin
          big_r <= big;
          sml_r <= sml_sh;
          sub_r <= big.sign ^ sml.sign;
        end
        ST_ADDS: begin
          sum_r  <= sum_nx;
          exp_r  <= big_r.exp;
          sign_r <= big_r.sign;
        end
        ST_NORM: begin
          result <= norm_res;
          flags  <= norm_flg;
        end
        default: ;
      endcase
    end
  end

endmodule
